// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache refill path.
package cache_pkg;

  localparam int CACHE_DATA_WIDTH = 32;
  localparam int CACHE_BLOCK_SIZE = 4;
  localparam int CACHE_ADDR_WIDTH = 32;
  localparam int BLK_OFF_W        = $clog2(CACHE_BLOCK_SIZE) + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_DONE
  } refill_state_t;

  typedef logic [CACHE_BLOCK_SIZE-1:0][CACHE_DATA_WIDTH-1:0] block_t;

  // Byte-offset width of a block: word index bits plus the two byte bits.
  function automatic int blk_off_w(input int block_size);
    return $clog2(block_size) + 2;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Refill sequencer: optional 4-beat victim write-back, then 4 single-outstanding
// read beats, delivering the assembled block with a one-cycle fetch_enable.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE,
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
  output logic                             fetch_enable,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int OFF_W  = blk_off_w(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  refill_state_t                            state;
  logic [BEAT_W-1:0]                        beat;
  logic [BEAT_W-1:0]                        beat_nxt;
  logic                                     beat_last;
  logic [ADDR_WIDTH-1:0]                    fill_base;
  logic [ADDR_WIDTH-1:0]                    wb_base;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    victim;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    fill_blk;

  // Block bases are aligned, so OR-ing the word offset is an add.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [BEAT_W-1:0]     b);
    return base | (ADDR_WIDTH'(b) << 2);
  endfunction

  assign beat_nxt   = beat + BEAT_W'(1);
  assign beat_last  = (beat == BEAT_W'(BLOCK_SIZE - 1));
  assign fetch_data = fill_blk;

  // All memory-side outputs are loaded on the transition into the state that
  // presents them, so nothing combinational reaches mem_req or busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat         <= '0;
      fill_base    <= '0;
      wb_base      <= '0;
      victim       <= '0;
      fill_blk     <= '0;
      fetch_enable <= 1'b0;
      busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      fetch_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (miss_req) begin
            fill_base <= miss_addr & ~OFF_MASK;
            beat      <= '0;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            if (wb_valid) begin
              wb_base   <= wb_addr & ~OFF_MASK;
              victim    <= wb_data;
              mem_we    <= 1'b1;
              mem_addr  <= wb_addr & ~OFF_MASK;
              mem_wdata <= wb_data[DATA_WIDTH-1:0];
              state     <= ST_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= miss_addr & ~OFF_MASK;
              state    <= ST_FILL_REQ;
            end
          end
        end
        ST_WB: begin
          if (mem_gnt) begin
            beat <= beat_nxt;
            if (beat_last) begin
              mem_we   <= 1'b0;
              mem_addr <= fill_base;
              state    <= ST_FILL_REQ;
            end else begin
              mem_addr  <= beat_addr(wb_base, beat_nxt);
              mem_wdata <= victim[beat_nxt];
            end
          end
        end
        ST_FILL_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_FILL_WAIT;
          end
        end
        ST_FILL_WAIT: begin
          if (mem_rvalid) begin
            fill_blk[beat] <= mem_rdata;
            beat           <= beat_nxt;
            if (beat_last) begin
              fetch_enable <= 1'b1;
              state        <= ST_DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= beat_addr(fill_base, beat_nxt);
              state    <= ST_FILL_REQ;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a word-wide memory model with random
// grant/latency feeds a transaction-level scoreboard of beats and refill blocks.
module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int BS = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            miss_req;
  logic [AW-1:0]   miss_addr;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [BS*DW-1:0] wb_data;
  logic [BS*DW-1:0] fetch_data;
  logic            fetch_enable;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .fetch_data(fetch_data), .fetch_enable(fetch_enable), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  beat_t          beat_q[$];
  logic [127:0]   blk_q[$];
  int             elat_q[$];
  int             t_q[$];
  int             rlat_q[$];
  logic [DW-1:0]  mem [logic [AW-1:0]];

  int n_chk = 0;
  int n_err = 0;

  bit            in_flight, prev_fe, prev_stall, prev_we, rd_pend;
  bit            accepted, fe_seen, stray, noise;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata, rd_data;
  int            rd_due, rd_cnt, wr_cnt, stall_left, stall_wr_beat, stall_rd_beat;
  int            gnt_pct, lat_min, lat_max, next_lat;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // One cycle of the memory model and scoreboard, evaluated at the falling edge;
  // the inputs it leaves behind are what the DUT samples on the next rising edge.
  task automatic evaluate();
    bit           g, done_seen;
    beat_t        b;
    int           lat;
    logic [AW-1:0] fb, wbb;
    logic [127:0] blk;
    accepted  = 0;
    fe_seen   = 0;
    done_seen = 0;
    if (rst) begin
      beat_q.delete(); blk_q.delete(); elat_q.delete(); t_q.delete();
      in_flight = 0; prev_fe = 0; prev_stall = 0; rd_pend = 0; stall_left = 0;
      mem_gnt = 0; mem_rvalid = 0;
      return;
    end

    chk("busy", busy, in_flight);
    if (!in_flight) chk("idle_req", mem_req, 0);
    if (prev_stall) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, prev_addr);
      chk("stall_we", mem_we, prev_we);
      if (prev_we) chk("stall_wdata", mem_wdata, prev_wdata);
    end
    if (prev_fe) chk("fe_pulse", fetch_enable, 0);
    prev_fe = fetch_enable;

    if (fetch_enable) begin
      fe_seen = 1;
      if (blk_q.size() == 0) chk("fe_spurious", 1, 0);
      else begin
        blk = blk_q.pop_front();
        lat = elat_q.pop_front();
        chk("fe_data", fetch_data, blk);
        if (lat >= 0) chk("fe_latency", cyc - t_q[0], lat);
        void'(t_q.pop_front());
        chk("beats_left", beat_q.size(), 0);
        done_seen = 1;
      end
    end

    if (rd_pend && cyc == rd_due) begin
      mem_rvalid = 1; mem_rdata = rd_data; rd_pend = 0;
    end else if (!rd_pend && stray && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1; mem_rdata = $urandom();
    end else begin
      mem_rvalid = 0; mem_rdata = $urandom();
    end

    if (stall_left == 0 && mem_req && in_flight) begin
      if (mem_we && wr_cnt == stall_wr_beat) begin stall_left = 3; stall_wr_beat = -1; end
      else if (!mem_we && rd_cnt == stall_rd_beat) begin stall_left = 3; stall_rd_beat = -1; end
    end
    if (stall_left > 0) begin g = 0; stall_left--; end
    else g = ($urandom_range(0, 99) < gnt_pct);
    mem_gnt    = g;
    prev_stall = mem_req && !g;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;

    if (mem_req && g) begin
      if (beat_q.size() == 0) chk("beat_extra", 1, 0);
      else begin
        b = beat_q.pop_front();
        chk("beat_we", mem_we, b.we);
        chk("beat_addr", mem_addr, b.addr);
        if (b.we) begin
          chk("beat_wdata", mem_wdata, b.wdata);
          mem[b.addr] = b.wdata;
          wr_cnt++;
        end else begin
          if (rlat_q.size() > 0) lat = rlat_q.pop_front();
          else lat = $urandom_range(lat_max, lat_min);
          rd_pend = 1;
          rd_due  = cyc + lat;
          rd_data = mem_rd(b.addr);
          rd_cnt++;
        end
      end
    end

    if (!in_flight && miss_req) begin
      fb  = miss_addr & ~32'hF;
      wbb = wb_addr & ~32'hF;
      for (int i = 0; i < BS; i++)
        if (wb_valid) beat_q.push_back('{1'b1, wbb + 32'(4 * i), wb_data[i*DW +: DW]});
      for (int i = 0; i < BS; i++) begin
        beat_q.push_back('{1'b0, fb + 32'(4 * i), '0});
        if (wb_valid && wbb == fb) blk[i*DW +: DW] = wb_data[i*DW +: DW];
        else blk[i*DW +: DW] = mem_rd(fb + 32'(4 * i));
      end
      blk_q.push_back(blk);
      elat_q.push_back(next_lat);
      t_q.push_back(cyc);
      in_flight = 1;
      wr_cnt    = 0;
      rd_cnt    = 0;
      accepted  = 1;
    end else if (done_seen) begin
      in_flight = 0;
    end
  endtask

  task automatic step();
    evaluate();
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [AW-1:0] ma, input logic wb, input logic [AW-1:0] wa,
                            input logic [127:0] wd, input int lat);
    int n;
    miss_addr = ma; wb_valid = wb; wb_addr = wa; wb_data = wd; next_lat = lat; miss_req = 1;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 20);
    chk("accept", accepted, 1);
  endtask

  task automatic wait_fe();
    int n;
    n = 0;
    do begin
      step(); n++;
      if (noise && !fe_seen) begin
        wb_valid = 1'($urandom()); wb_addr = $urandom(); miss_addr = $urandom();
        wb_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end while (!fe_seen && n < 1000);
    chk("fe_arrived", fe_seen, 1);
  endtask

  task automatic run_miss(input logic [AW-1:0] ma, input logic wb, input logic [AW-1:0] wa,
                          input logic [127:0] wd, input int lat, input bit keep);
    start_miss(ma, wb, wa, wd, lat);
    wait_fe();
    if (!keep) begin miss_req = 0; wb_valid = 0; end
  endtask

  initial begin
    int n;
    rst = 1; miss_req = 0; miss_addr = '0; wb_valid = 0; wb_addr = '0; wb_data = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; stray = 0; noise = 0;
    stall_wr_beat = -1; stall_rd_beat = -1; next_lat = -1;
    step(); step();
    rst = 0;
    chk("rst_busy0", busy, 0);
    chk("rst_req0", mem_req, 0);
    chk("rst_we0", mem_we, 0);
    chk("rst_addr0", mem_addr, 0);
    chk("rst_wdata0", mem_wdata, 0);
    chk("rst_fe0", fetch_enable, 0);
    chk("rst_fdata0", fetch_data, 0);
    step(); step();

    // clean miss
    for (int i = 0; i < 4; i++) mem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
    run_miss(32'h0000_1234, 0, 32'h0, '0, 9, 0);
    chk("clean_blk", fetch_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    step();

    // dirty miss
    for (int i = 0; i < 4; i++) mem[32'h80 + 32'(4 * i)] = 32'hB0 + 32'(i);
    run_miss(32'h80, 1, 32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 13, 0);
    chk("dirty_blk", fetch_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    chk("dirty_wr3", mem[32'h4C], 32'h44);
    step();

    // backpressure on write beat 2 and read beat 1
    stall_wr_beat = 2; stall_rd_beat = 1;
    run_miss(32'h184, 1, 32'h148, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 19, 0);
    step();

    // variable read latency with stray rvalid pulses
    stray = 1;
    rlat_q = '{1, 5, 2, 7};
    run_miss(32'h1C8, 0, 32'h0, '0, 20, 0);
    step(); step();

    // reset in the middle of the fill
    stray = 0;
    start_miss(32'h500, 1, 32'h540, {32'h4, 32'h3, 32'h2, 32'h1}, -1);
    n = 0;
    while (rd_cnt < 3 && n < 100) begin step(); n++; end
    chk("rst_reach", rd_cnt, 3);
    miss_req = 0; wb_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_req", mem_req, 0);
    chk("midrst_fe", fetch_enable, 0);
    repeat (6) step();
    run_miss(32'h600, 0, 32'h0, '0, 9, 0);
    step();

    // back-to-back: miss_req held across DONE with a new address
    run_miss(32'h300, 0, 32'h0, '0, 9, 1);
    miss_addr = 32'h200; next_lat = 9;
    step();
    chk("b2b_accept", accepted, 1);
    wait_fe();
    miss_req = 0;
    step();

    // randomized traffic
    stray = 1; noise = 1; lat_min = 1; lat_max = 6;
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] ma, wa;
      gnt_pct = $urandom_range(40, 100);
      ma = $urandom();
      wa = ($urandom_range(0, 3) == 0) ? ma : $urandom();
      run_miss(ma, 1'($urandom()), wa, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0);
      repeat ($urandom_range(0, 3)) begin
        wb_valid = 1'($urandom());
        step();
      end
      wb_valid = 0;
    end
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Memory-side partner of the data cache: consumes the cache's miss request and dirty-block write-back, and produces the refill block (fetch_data/fetch_enable) that the cache loads.
- Sits between the cache and word-wide main memory; sequences 4 write beats (victim write-back, when present) and then 4 read beats, one memory transaction outstanding at a time.

Parameters:
DATA_WIDTH, 32, word width in bits
BLOCK_SIZE, 4, words per cache block (beats per transfer)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
miss_req  in  1  cache requests a block refill; level, held until fetch_enable
miss_addr  in  ADDR_WIDTH  byte address of the missing access
wb_valid  in  1  dirty victim must be written before refill; sampled with miss_req
wb_addr  in  ADDR_WIDTH  victim block base address
wb_data  in  BLOCK_SIZE*DATA_WIDTH  victim block; word i at [i*DATA_WIDTH +: DATA_WIDTH]
fetch_data  out  BLOCK_SIZE*DATA_WIDTH  refilled block, same word packing
fetch_enable  out  1  one-cycle pulse: fetch_data valid, refill complete
busy  out  1  controller not in IDLE
mem_req  out  1  memory beat request
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  ADDR_WIDTH  word-aligned beat address
mem_wdata  out  DATA_WIDTH  write beat data
mem_gnt  in  1  memory accepts beat this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  read data returned, earliest the cycle after grant
mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset: state IDLE, beat counter 0, fetch_data 0, fetch_enable 0, busy 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0; latched addresses/victim cleared.
- States: IDLE, WB, FILL_REQ, FILL_WAIT, DONE.
- IDLE: when miss_req=1, latch fill_base = miss_addr with low log2(BLOCK_SIZE)+2 bits cleared. If wb_valid=1, also latch wb_addr (low bits cleared) and wb_data, then go to WB; otherwise go to FILL_REQ. Beat counter = 0.
- WB: mem_req=1, mem_we=1, mem_addr = wb_base + 4*beat, mem_wdata = victim word[beat]. On mem_gnt, beat++. On the grant of the last beat, beat wraps to 0 and state goes to FILL_REQ. Without grant, all outputs hold.
- FILL_REQ: mem_req=1, mem_we=0, mem_addr = fill_base + 4*beat. On mem_gnt, go to FILL_WAIT.
- FILL_WAIT: mem_req=0. On mem_rvalid, write mem_rdata into fetch_data word[beat] and beat++. After the last beat go to DONE (beat wraps to 0); otherwise go to FILL_REQ.
- DONE: fetch_enable=1 for exactly this cycle; next state is IDLE. fetch_data holds its value until the next accepted request overwrites words.
- busy = (state != IDLE). Outputs are driven from registered state and counter only; there is no combinational path from inputs to mem_req or busy.
- Latency with mem_gnt tied 1 and rvalid one cycle after grant:
  - clean miss accepted at cycle T: fetch_enable at T+9;
  - dirty miss: fetch_enable at T+13.
- miss_req while busy: ignored; the request is not re-sampled. In the IDLE cycle after DONE, a still-high miss_req is accepted as a new request.
- Ignored inputs:
  - mem_rvalid outside FILL_WAIT;
  - wb_valid without miss_req;
  - mem_gnt while mem_req=0.
- rst asserted in any state: return to IDLE next edge with reset values. The in-flight beat is abandoned and no fetch_enable is issued.

Decomposition:
- Shared package cache_pkg: DATA_WIDTH/BLOCK_SIZE constants, block offset width, state enum refill_state_t, block type (packed array BLOCK_SIZE x DATA_WIDTH).
- No sub-module needed. Beat counter and block packing are inline.

Test Plan:
- Clean miss: miss_req=1, miss_addr=0x0000_1234, wb_valid=0, memory returns 0xA0..0xA3 -> read beats at 0x1230, 0x1234, 0x1238, 0x123C; fetch_data = {0xA3,0xA2,0xA1,0xA0}; fetch_enable single pulse at T+9.
- Dirty miss: wb_valid=1, wb_addr=0x0000_0040, wb_data words 0x11..0x44, miss_addr=0x80 -> writes at 0x40..0x4C with data 0x11, 0x22, 0x33, 0x44, then reads at 0x80..0x8C; fetch_enable at T+13.
- Backpressure: mem_gnt low 3 cycles on WB beat 2 and FILL beat 1 -> mem_addr/mem_wdata stable while stalled, no skipped or duplicated beats, fetch_enable delayed by 6 cycles.
- Variable read latency: rvalid 1, 5, 2, 7 cycles after each grant; stray rvalid pulses in FILL_REQ/IDLE -> only in-window data captured, correct word order.
- Reset mid-fill: rst for one cycle after beat 2 grant -> busy=0 and mem_req=0 next cycle, no fetch_enable; a new miss then completes normally.
- Back-to-back: miss_req held high across DONE with new miss_addr=0x200 -> second request accepted in the IDLE cycle after the pulse, beats at 0x200..0x20C.
